// File: rtl/data_mem_ctrl_if.sv
// Request/response bus for data_mem_ctrl: valid/ready request channel and
// valid/ready response channel carrying read data and an error flag.
interface data_mem_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_be;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Word memory with byte-enable writes, 1-cycle valid/ready responses and a
// reset sweep writing mem[i]=i. `define DMEM_PARITY_EN adds per-word even parity.
module data_mem_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 512
) (
    input  logic           clk,
    input  logic           reset,
    data_mem_ctrl_if.slave bus,
`ifdef DMEM_PARITY_EN
    input  logic           parity_inject,
`endif
    output logic           init_busy
);
    localparam int              BE_W      = DATA_W / 8;
    localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic [0:0] {INIT = 1'b0, RUN = 1'b1} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IDX_W-1:0]    r_sweep;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_rsp_err;
    logic                w_ready;
    logic                w_accept;
    logic                w_in_range;
    logic                w_rd_err;
    logic [IDX_W-1:0]    w_idx;
    logic [DATA_W-1:0]   w_old;
    logic [DATA_W-1:0]   w_merged;
    logic [DATA_W-1:0]   w_init_word;

    function automatic logic par_even(input logic [DATA_W-1:0] word);
        return ^word;
    endfunction

    assign w_idx       = bus.req_addr[IDX_W-1:0];
    assign w_in_range  = ({1'b0, bus.req_addr} < DEPTH_EXT);
    assign w_old       = mem[w_idx];
    assign w_init_word = DATA_W'(r_sweep);
    assign w_accept    = bus.req_valid & w_ready;

    assign bus.req_ready = w_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= INIT;
        else        r_state <= w_state_nxt;
    end

    // Next state and state-derived outputs
    always_comb begin
        w_state_nxt = r_state;
        init_busy   = 1'b1;
        w_ready     = 1'b0;
        case (r_state)
            INIT: begin
                init_busy = 1'b1;
                w_ready   = 1'b0;
                if (r_sweep == LAST_IDX) w_state_nxt = RUN;
                else                     w_state_nxt = INIT;
            end
            RUN: begin
                init_busy   = 1'b0;
                w_ready     = ~r_rsp_valid | bus.rsp_ready;
                w_state_nxt = RUN;
            end
            default: begin
                init_busy   = 1'b1;
                w_ready     = 1'b0;
                w_state_nxt = INIT;
            end
        endcase
    end

    // Sweep address counter, held at zero outside INIT
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                        r_sweep <= '0;
        else if (r_state == INIT && r_sweep != LAST_IDX)   r_sweep <= r_sweep + IDX_W'(1);
        else                                               r_sweep <= '0;
    end

    // Byte-enable merge of write data over the stored word
    always_comb begin
        w_merged = w_old;
        for (int k = 0; k < BE_W; k++) begin
            if (bus.req_be[k]) w_merged[8*k +: 8] = bus.req_wdata[8*k +: 8];
            else               w_merged[8*k +: 8] = w_old[8*k +: 8];
        end
    end

    // Memory array: no reset, contents come from the sweep or accepted writes
    always_ff @(posedge clk) begin
        if (r_state == INIT)                           mem[r_sweep] <= w_init_word;
        else if (w_accept && bus.req_we && w_in_range) mem[w_idx]   <= w_merged;
    end

`ifdef DMEM_PARITY_EN
    logic r_par [DEPTH];

    // Parity array; parity_inject stores the inverted bit to model corruption
    always_ff @(posedge clk) begin
        if (r_state == INIT)
            r_par[r_sweep] <= par_even(w_init_word);
        else if (w_accept && bus.req_we && w_in_range)
            r_par[w_idx] <= par_even(w_merged) ^ parity_inject;
    end

    assign w_rd_err = (r_par[w_idx] != par_even(w_old));
`else
    assign w_rd_err = 1'b0;
`endif

    // Response register, held until consumed or replaced back-to-back
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else if (w_accept) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= (!bus.req_we && w_in_range) ? w_old : '0;
            r_rsp_err   <= ~w_in_range | (~bus.req_we & w_rd_err);
        end else if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end else begin
            r_rsp_valid <= r_rsp_valid;
        end
    end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed testbench for data_mem_ctrl (DATA_W=16, ADDR_W=10, DEPTH=512).
module tb_data_mem_ctrl;
    logic clk;
    logic reset;
    logic init_busy;
`ifdef DMEM_PARITY_EN
    logic parity_inject;
`endif
    int   n_chk;
    int   n_err;
    int   cnt;
    logic rdy_seen;

    data_mem_ctrl_if #(.DATA_W(16), .ADDR_W(10)) bus ();

    data_mem_ctrl #(.DATA_W(16), .ADDR_W(10), .DEPTH(512)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
`ifdef DMEM_PARITY_EN
        .parity_inject (parity_inject),
`endif
        .init_busy (init_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Release reset on a falling edge and count cycles spent in the sweep
    task automatic count_init(output int c, output logic rdy);
        @(negedge clk);
        reset = 1'b1;
        #1;
        c   = 0;
        rdy = 1'b0;
        while (init_busy && c < 2000) begin
            if (bus.req_ready) rdy = 1'b1;
            c++;
            @(negedge clk);
            #1;
        end
    endtask

    task automatic xfer(input string tag, input logic we, input logic [9:0] addr,
                        input logic [15:0] wdata, input logic [1:0] be,
                        input logic [15:0] exp_rdata, input logic exp_err);
        int n;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_be    = be;
        bus.req_valid = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_ready"}, {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        chk({tag, "_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
        chk({tag, "_rdata"}, {16'd0, bus.rsp_rdata}, {16'd0, exp_rdata});
        chk({tag, "_err"},   {31'd0, bus.rsp_err},   {31'd0, exp_err});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0;
        n_err = 0;
        reset = 1'b0;
`ifdef DMEM_PARITY_EN
        parity_inject = 1'b0;
`endif
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 10'h005;
        bus.req_wdata = 16'h0000;
        bus.req_be    = 2'b00;
        bus.rsp_ready = 1'b1;
        #23;
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", {16'd0, bus.rsp_rdata}, 32'd0);
        chk("rst_rsp_err",   {31'd0, bus.rsp_err},   32'd0);
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
        chk("rst_init_busy", {31'd0, init_busy},     32'd1);

        // Sweep with req_valid held high
        count_init(cnt, rdy_seen);
        chk("init_cycles",    cnt, 32'd512);
        chk("init_ready_low", {31'd0, rdy_seen}, 32'd0);
        xfer("rd005", 1'b0, 10'h005, 16'h0000, 2'b00, 16'h0005, 1'b0);

        // Byte-enable writes and read-after-write
        xfer("wr010",   1'b1, 10'h010, 16'hABCD, 2'b01, 16'h0000, 1'b0);
        xfer("rd010",   1'b0, 10'h010, 16'h0000, 2'b00, 16'h00CD, 1'b0);
        xfer("wr011",   1'b1, 10'h011, 16'h1234, 2'b10, 16'h0000, 1'b0);
        xfer("rd011",   1'b0, 10'h011, 16'h0000, 2'b00, 16'h1211, 1'b0);
        xfer("wr012",   1'b1, 10'h012, 16'hFFFF, 2'b00, 16'h0000, 1'b0);
        xfer("rd012",   1'b0, 10'h012, 16'h0000, 2'b00, 16'h0012, 1'b0);
        xfer("wr013",   1'b1, 10'h013, 16'hBEEF, 2'b11, 16'h0000, 1'b0);
        xfer("rd013",   1'b0, 10'h013, 16'h0000, 2'b00, 16'hBEEF, 1'b0);

        // Address range boundary
        xfer("rd200",   1'b0, 10'h200, 16'h0000, 2'b00, 16'h0000, 1'b1);
        xfer("rd1ff",   1'b0, 10'h1FF, 16'h0000, 2'b00, 16'h01FF, 1'b0);
        xfer("wr3ff",   1'b1, 10'h3FF, 16'h5555, 2'b11, 16'h0000, 1'b1);
        xfer("rd0ff",   1'b0, 10'h0FF, 16'h0000, 2'b00, 16'h00FF, 1'b0);

        // Response backpressure
        xfer("rd003",   1'b0, 10'h003, 16'h0000, 2'b00, 16'h0003, 1'b0);
        bus.rsp_ready = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = 10'h004;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("bp_valid", {31'd0, bus.rsp_valid}, 32'd1);
            chk("bp_rdata", {16'd0, bus.rsp_rdata}, 32'h0003);
            chk("bp_ready", {31'd0, bus.req_ready}, 32'd0);
        end
        bus.rsp_ready = 1'b1;
        #1;
        chk("bp_ready_rise", {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        chk("b2b_valid", {31'd0, bus.rsp_valid}, 32'd1);
        chk("b2b_rdata", {16'd0, bus.rsp_rdata}, 32'h0004);
        @(posedge clk);
        #1;
        chk("drain_valid", {31'd0, bus.rsp_valid}, 32'd0);

`ifdef DMEM_PARITY_EN
        parity_inject = 1'b1;
        xfer("par_wr_inj", 1'b1, 10'h020, 16'h0042, 2'b11, 16'h0000, 1'b0);
        parity_inject = 1'b0;
        xfer("par_rd_bad", 1'b0, 10'h020, 16'h0000, 2'b00, 16'h0042, 1'b1);
        xfer("par_wr_ok",  1'b1, 10'h020, 16'h0042, 2'b11, 16'h0000, 1'b0);
        xfer("par_rd_ok",  1'b0, 10'h020, 16'h0000, 2'b00, 16'h0042, 1'b0);
`endif

        // Reset while a response is pending
        xfer("rd007",   1'b0, 10'h007, 16'h0000, 2'b00, 16'h0007, 1'b0);
        bus.rsp_ready = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("prst_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("prst_rdata", {16'd0, bus.rsp_rdata}, 32'd0);
        chk("prst_busy",  {31'd0, init_busy},     32'd1);
        bus.rsp_ready = 1'b1;
        count_init(cnt, rdy_seen);
        chk("prst_cycles", cnt, 32'd512);

        // Reset mid-sweep at counter 100
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (100) @(negedge clk);
        #1;
        chk("mid_busy_pre", {31'd0, init_busy}, 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_busy",  {31'd0, init_busy},     32'd1);
        chk("mid_ready", {31'd0, bus.req_ready}, 32'd0);
        count_init(cnt, rdy_seen);
        chk("mid_cycles", cnt, 32'd512);
        chk("mid_ready_low", {31'd0, rdy_seen}, 32'd0);
        xfer("resweep010", 1'b0, 10'h010, 16'h0000, 2'b00, 16'h0010, 1'b0);
        xfer("resweep013", 1'b0, 10'h013, 16'h0000, 2'b00, 16'h0013, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL provide parameter DATA_W, default 16, word width in bits (multiple of 8).
REQ-002 SHALL provide parameter ADDR_W, default 10, request address width.
REQ-003 SHALL provide parameter DEPTH, default 512, number of words (DEPTH <= 2^ADDR_W).
REQ-004 SHALL provide port clk  input  1  rising-edge clock.
REQ-005 SHALL provide port reset  input  1  reset, asynchronous, active-low.
REQ-006 SHALL provide port req_valid  input  1  request present.
REQ-007 SHALL provide port req_ready  output  1  request accepted when high with req_valid.
REQ-008 SHALL provide port req_we  input  1  1 = write, 0 = read.
REQ-009 SHALL provide port req_addr  input  ADDR_W  word address.
REQ-010 SHALL provide port req_wdata  input  DATA_W  write data.
REQ-011 SHALL provide port req_be  input  DATA_W/8  byte write enables, bit k covers bits 8k+7:8k.
REQ-012 SHALL provide port rsp_valid  output  1  response present.
REQ-013 SHALL provide port rsp_ready  input  1  response consumed when high with rsp_valid.
REQ-014 SHALL provide port rsp_rdata  output  DATA_W  read data; 0 for writes and errors.
REQ-015 SHALL provide port rsp_err  output  1  response error flag.
REQ-016 SHALL provide port init_busy  output  1  initialisation sweep in progress.

Function
REQ-017 SHALL implement FSM states INIT, RUN; reset enters INIT.
REQ-018 INIT SHALL write mem[i] = i (truncated/zero-extended to DATA_W), one word per cycle, i = 0..DEPTH-1, then enter RUN; init_busy=1 throughout INIT, 0 in RUN.
REQ-019 req_ready SHALL equal RUN & (~rsp_valid | rsp_ready); req_ready=0 during INIT regardless of req_valid.
REQ-020 A request SHALL be accepted on a rising edge with req_valid & req_ready; the response SHALL appear with rsp_valid=1 on the following cycle (latency 1).
REQ-021 Read: rsp_rdata = mem[req_addr] as of acceptance edge, rsp_err=0.
REQ-022 Write: bytes with req_be[k]=1 updated at acceptance edge, others retained; response rsp_rdata=0, rsp_err=0; req_be=0 is a legal no-op write with normal ack.
REQ-023 req_addr >= DEPTH: no memory update, response rsp_err=1, rsp_rdata=0.
REQ-024 rsp_valid, rsp_rdata, rsp_err SHALL hold stable until rsp_ready=1; rsp_valid clears after consumption unless a new request is accepted on the same edge (back-to-back, full throughput).
REQ-025 Read accepted the cycle after a write to the same address SHALL return the written data.
REQ-026 Request inputs SHALL be ignored when req_ready=0.

Reset
REQ-027 On reset low: state=INIT, sweep counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=0, init_busy=1.
REQ-028 Reset asserted mid-sweep or mid-transaction SHALL discard any pending response and restart the INIT sweep from address 0.
REQ-029 Memory array SHALL not be reset directly; contents are defined only by the INIT sweep.

Configuration
REQ-030 Macro DMEM_PARITY_EN defined: one even-parity bit per word stored, computed over the merged post-write word (and by INIT); read with parity mismatch SHALL return data with rsp_err=1; extra input port parity_inject (1 bit) SHALL, on an accepted write, store the inverted parity.
REQ-031 Macro DMEM_PARITY_EN undefined: no parity storage, no parity_inject port, rsp_err driven only by REQ-023.

Verification (DATA_W=16, DEPTH=512)
REQ-032 Release reset, hold req_valid=1 -> init_busy=1 and req_ready=0 for exactly 512 cycles, then read addr 0x005 -> rsp_rdata=0x0005, rsp_err=0.
REQ-033 Write addr 0x010 data 0xABCD be=2'b01, then read 0x010 -> rsp_rdata=0x00CD.
REQ-034 Read addr 0x200 -> rsp_err=1, rsp_rdata=0; then read 0x1FF -> 0x01FF, rsp_err=0.
REQ-035 Issue read 0x003 with rsp_ready=0 for 3 cycles -> rsp_valid held, rsp_rdata=0x0003 stable, req_ready=0; raise rsp_ready -> next request accepted same edge.
REQ-036 Assert reset mid-sweep at counter 100 and during a pending response -> rsp_valid=0 immediately, sweep restarts at 0, 512 busy cycles after release.
REQ-037 With DMEM_PARITY_EN: write 0x0042 addr 0x020 with parity_inject=1, read 0x020 -> rsp_rdata=0x0042, rsp_err=1; rewrite without inject -> rsp_err=0.
